// File: rtl/fft_spectrum_buf.sv
// FFT spectrum post-processor: captures one frame of magnitude bins per fft_done edge,
// combines each bin with the previous frame (pass/average/peak) into a ping-pong store.
module fft_spectrum_buf #(
  parameter int unsigned RN        = 16,
  parameter int unsigned SIZE      = 32,
  parameter int unsigned LAT       = 2,
  parameter int unsigned AVG_SHIFT = 3,
  parameter int unsigned DEC_SHIFT = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fft_done,
  output logic                    fft_shift,
  input  logic [RN-1:0]           fft_data,
  input  logic [1:0]              mode,
  input  logic                    clr,
  input  logic [$clog2(SIZE)-1:0] rd_addr,
  output logic [RN-1:0]           rd_data,
  output logic                    frame_tick,
  output logic                    busy
);

  localparam int unsigned AW = $clog2(SIZE);
  localparam logic [AW-1:0] LAST = AW'(SIZE - 1);
  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_AVG  = 2'd1;
  localparam logic [1:0] MODE_PEAK = 2'd2;

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, SWAP} state_t;

  state_t          state, state_nxt;
  logic            done_q;
  logic            clr_pend;
  logic [1:0]      mode_q;
  logic            sel;
  logic [AW-1:0]   iss_cnt;
  logic [AW-1:0]   cap_cnt;
  logic [LAT-1:0]  vpipe;
  logic            cap_valid;
  logic            start;
  logic [RN-1:0]   bank0 [SIZE];
  logic [RN-1:0]   bank1 [SIZE];
  logic [RN-1:0]   old_v;
  logic [RN-1:0]   new_v;
  logic [RN-1:0]   dec_v;
  logic signed [RN:0] in_s, old_s, diff_s, avg_s;
  logic            rd_sel;

  assign cap_valid = vpipe[LAT-1];
  assign start     = (state == IDLE) && fft_done && !done_q;
  // During SWAP the readout already points at the bank about to become visible.
  assign rd_sel    = (state == SWAP) ? ~sel : sel;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: if (iss_cnt == LAST) state_nxt = DRAIN;
      DRAIN: if (cap_valid && (cap_cnt == LAST)) state_nxt = SWAP;
      SWAP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bin combine: old value comes from the display bank at the capture address.
  always_comb begin
    old_v  = sel ? bank1[cap_cnt] : bank0[cap_cnt];
    in_s   = {1'b0, fft_data};
    old_s  = {1'b0, old_v};
    diff_s = in_s - old_s;
    avg_s  = old_s + (diff_s >>> AVG_SHIFT);
    dec_v  = old_v - (old_v >> DEC_SHIFT);
    case (mode_q)
      MODE_AVG:  new_v = avg_s[RN-1:0];
      MODE_PEAK: new_v = (fft_data > dec_v) ? fft_data : dec_v;
      default:   new_v = fft_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      done_q     <= 1'b0;
      clr_pend   <= 1'b0;
      mode_q     <= MODE_PASS;
      sel        <= 1'b0;
      iss_cnt    <= '0;
      cap_cnt    <= '0;
      vpipe      <= '0;
      fft_shift  <= 1'b0;
      frame_tick <= 1'b0;
      busy       <= 1'b0;
      rd_data    <= '0;
      for (int i = 0; i < int'(SIZE); i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else begin
      state      <= state_nxt;
      done_q     <= fft_done;
      fft_shift  <= (state_nxt == SHIFT);
      frame_tick <= (state_nxt == SWAP);
      busy       <= (state_nxt != IDLE);
      vpipe      <= LAT'({vpipe, fft_shift});
      rd_data    <= rd_sel ? bank1[rd_addr] : bank0[rd_addr];

      if (start) begin
        mode_q   <= (clr_pend || clr) ? MODE_PASS : mode;
        clr_pend <= 1'b0;
        iss_cnt  <= '0;
        cap_cnt  <= '0;
      end else begin
        if (clr) clr_pend <= 1'b1;
        if (state == SHIFT) iss_cnt <= iss_cnt + AW'(1);
        if (cap_valid) cap_cnt <= cap_cnt + AW'(1);
      end

      if (cap_valid) begin
        if (sel) bank0[cap_cnt] <= new_v;
        else     bank1[cap_cnt] <= new_v;
      end

      if (state == SWAP) sel <= ~sel;
    end
  end

endmodule
